// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, NOP, ROM width, FSM encoding.
package fetch_stage_pkg;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_J     = 5'd1;
    localparam logic [4:0] OP_BNE   = 5'd2;
    localparam logic [4:0] OP_JAL   = 5'd3;
    localparam logic [4:0] OP_JR    = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;
    localparam logic [4:0] OP_SETX  = 5'd21;
    localparam logic [4:0] OP_BEX   = 5'd22;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          IMEM_AW   = 12;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[31:27];
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register: sync reset, then load, then increment when enabled.
module pc_register #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    // Next PC: a load wins over the enable so redirects land even under stall.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (en_i) begin
            pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= {W{1'b0}};
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register over a 1-cycle-latency ROM.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [4:0]  if_id_opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_squashed
`endif
);

    logic [31:0]  pc_s;
    logic [31:0]  req_pc_q, req_pc_d;
    fetch_state_e state_q, state_d;
    logic         req_valid_q;
    logic         if_id_valid_q, if_id_valid_d;
    logic [31:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;

    pc_register #(.W(32)) u_pc (
        .clk_i      (clock),
        .rst_i      (reset),
        .en_i       (!stall),
        .load_i     (redirect_valid),
        .load_val_i (redirect_pc),
        .pc_o       (pc_s)
    );

    // RUN means the ROM output this cycle belongs to req_pc_q.
    assign req_valid_q = (state_q == ST_RUN);

    // While stalled, re-present req_pc_q so the ROM keeps returning its data.
    assign imem_addr = stall ? req_pc_q[IMEM_AW-1:0] : pc_s[IMEM_AW-1:0];

    // Next-state and IF/ID update: redirect squashes, stall holds, else advance.
    always_comb begin
        req_pc_d      = req_pc_q;
        state_d       = state_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if (redirect_valid) begin
            state_d       = ST_FILL;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (stall) begin
            state_d = state_q;
        end else begin
            req_pc_d      = pc_s;
            state_d       = ST_RUN;
            if_id_valid_d = req_valid_q;
            if_id_pc_d    = req_pc_q;
            case (state_q)
                ST_RUN:  if_id_instr_d = imem_data;
                ST_FILL: if_id_instr_d = NOP_INSTR;
                default: if_id_instr_d = NOP_INSTR;
            endcase
        end
    end

    // Fetch state and IF/ID registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_pc_q      <= 32'h0000_0000;
            state_q       <= ST_FILL;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            req_pc_q      <= req_pc_d;
            state_q       <= state_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign if_id_valid  = if_id_valid_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_opcode = opcode_of(if_id_instr_q);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_squashed_q, perf_squashed_d;
    logic [1:0]  squash_cnt_s;
    logic [16:0] squash_sum_s;

    assign squash_cnt_s = {1'b0, req_valid_q} + {1'b0, if_id_valid_q};
    assign squash_sum_s = {1'b0, perf_squashed_q} + {15'd0, squash_cnt_s};

    // Counter next-state; the squash count saturates instead of wrapping.
    always_comb begin
        perf_fetched_d  = perf_fetched_q;
        perf_squashed_d = perf_squashed_q;
        if (redirect_valid) begin
            perf_squashed_d = squash_sum_s[16] ? 16'hFFFF : squash_sum_s[15:0];
        end else if (!stall && req_valid_q) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end else begin
            perf_fetched_d = perf_fetched_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_q  <= 32'd0;
            perf_squashed_q <= 16'd0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a behavioural 1-cycle ROM.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [4:0]  if_id_opcode;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_squashed;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_opcode   (if_id_opcode)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM[n] = n + 0x100, except the top page which carries a nonzero opcode.
    function automatic logic [31:0] rom(input logic [11:0] a);
        if (a >= 12'hF00) return {a[4:0], 15'h0000, a};
        else              return 32'h0000_0100 + {20'h00000, a};
    endfunction

    always @(posedge clock) imem_data <= rom(imem_addr);

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdv;
        logic [31:0] rdpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [11:0] eaddr;
        logic [31:0] efet;
        logic [15:0] esq;
    } vec_t;

    vec_t vecs[39];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic ev, input logic chk_pc,
                                 input logic [31:0] epc, input logic [31:0] einstr,
                                 input logic [11:0] eaddr, input logic [31:0] efet,
                                 input logic [15:0] esq);
        logic [31:0] eop;
        eop = {27'd0, einstr[31:27]};
        chk($sformatf("valid[%0d]", idx), {31'd0, if_id_valid}, {31'd0, ev});
        chk($sformatf("instr[%0d]", idx), if_id_instr, einstr);
        chk($sformatf("opcode[%0d]", idx), {27'd0, if_id_opcode}, eop);
        chk($sformatf("imem_addr[%0d]", idx), {20'd0, imem_addr}, {20'd0, eaddr});
        if (chk_pc) chk($sformatf("pc[%0d]", idx), if_id_pc, epc);
`ifdef FETCH_PERF_EN
        chk($sformatf("perf_fetched[%0d]", idx), perf_fetched, efet);
        chk($sformatf("perf_squashed[%0d]", idx), {16'd0, perf_squashed}, {16'd0, esq});
`else
        if (efet === 32'hFFFF_FFFF && esq === 16'hFFFF) $display("note: unused perf expectation");
`endif
    endtask

    initial begin
        //            rst   stl   rdv   rdpc           ev    epc            einstr         eaddr    fet    sq
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h000, 32'd0,  16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h001, 32'd0,  16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h100,       12'h002, 32'd1,  16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1,         32'h101,       12'h003, 32'd2,  16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h2,         32'h102,       12'h004, 32'd3,  16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h3,         32'h103,       12'h005, 32'd4,  16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         32'h104,       12'h006, 32'd5,  16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h5,         32'h105,       12'h007, 32'd6,  16'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h5,         32'h105,       12'h006, 32'd6,  16'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h5,         32'h105,       12'h006, 32'd6,  16'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h5,         32'h105,       12'h006, 32'd6,  16'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h6,         32'h106,       12'h008, 32'd7,  16'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h7,         32'h107,       12'h009, 32'd8,  16'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'h108,       12'h00A, 32'd9,  16'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h9,         32'h109,       12'h00B, 32'd10, 16'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h40,        1'b0, 32'h0,         32'h0,         12'h040, 32'd10, 16'd2};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h041, 32'd10, 16'd2};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h40,        32'h140,       12'h042, 32'd11, 16'd2};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h80,        1'b0, 32'h0,         32'h0,         12'h041, 32'd11, 16'd4};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h041, 32'd11, 16'd4};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h081, 32'd11, 16'd4};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h80,        32'h180,       12'h082, 32'd12, 16'd4};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 32'h100,       1'b0, 32'h0,         32'h0,         12'h100, 32'd12, 16'd6};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 32'h200,       1'b0, 32'h0,         32'h0,         12'h200, 32'd12, 16'd6};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h201, 32'd12, 16'd6};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,       32'h300,       12'h202, 32'd13, 16'd6};
        vecs[26] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0,         12'hFFF, 32'd13, 16'd8};
        vecs[27] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h000, 32'd13, 16'd8};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF, 32'hF800_0FFF, 12'h001, 32'd14, 16'd8};
        vecs[29] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h100,       12'h002, 32'd15, 16'd8};
        vecs[30] = '{1'b0, 1'b0, 1'b1, 32'h1E,        1'b0, 32'h0,         32'h0,         12'h01E, 32'd15, 16'd10};
        vecs[31] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h01F, 32'd15, 16'd10};
        vecs[32] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1E,        32'h11E,       12'h020, 32'd16, 16'd10};
        vecs[33] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1F,        32'h11F,       12'h021, 32'd17, 16'd10};
        vecs[34] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h20,        32'h120,       12'h022, 32'd18, 16'd10};
        vecs[35] = '{1'b1, 1'b0, 1'b1, 32'h55,        1'b0, 32'h0,         32'h0,         12'h000, 32'd0,  16'd0};
        vecs[36] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         12'h001, 32'd0,  16'd0};
        vecs[37] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h100,       12'h002, 32'd1,  16'd0};
        vecs[38] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1,         32'h101,       12'h003, 32'd2,  16'd0};

        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 39; i++) begin
            reset          = vecs[i].rst;
            stall          = vecs[i].stl;
            redirect_valid = vecs[i].rdv;
            redirect_pc    = vecs[i].rdpc;
            @(posedge clock);
            #1;
            check_outputs(i, vecs[i].ev, vecs[i].ev | vecs[i].rst, vecs[i].epc,
                          vecs[i].einstr, vecs[i].eaddr, vecs[i].efet, vecs[i].esq);
        end

        // Long stall: IF/ID must hold pc 1 and the ROM must keep seeing address 2.
        reset          = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            check_outputs(100 + c, 1'b1, 1'b1, 32'h1, 32'h101, 12'h002, 32'd2, 16'd0);
        end
        stall = 1'b0;
        @(posedge clock);
        #1;
        check_outputs(200, 1'b1, 1'b1, 32'h2, 32'h102, 12'h004, 32'd3, 16'd0);
        @(posedge clock);
        #1;
        check_outputs(201, 1'b1, 1'b1, 32'h3, 32'h103, 12'h005, 32'd4, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
